// File: rtl/bldc_encoder_emulator_if.sv
`default_nettype none
// ============================================================================
// Module   : bldc_encoder_emulator_if
// Purpose  : Command/status bundle for the BLDC quadrature encoder emulator.
// Revision : 1.0
// ============================================================================
interface bldc_encoder_emulator_if #(
    parameter int COUNT_WIDTH  = 15,
    parameter int PERIOD_WIDTH = 16
);
    logic                    load;
    logic [COUNT_WIDTH-1:0]  target;
    logic [PERIOD_WIDTH-1:0] step_period;
    logic [1:0]              enc;
    logic [COUNT_WIDTH-1:0]  position;
    logic                    busy;
    logic                    done;

    modport master (
        output load, target, step_period,
        input  enc, position, busy, done
    );

    modport slave (
        input  load, target, step_period,
        output enc, position, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/bldc_encoder_emulator.sv
`default_nettype none
// ============================================================================
// Module   : bldc_encoder_emulator
// Purpose  : Steps an emulated quadrature pair toward a target at a set rate.
// Revision : 1.0
// ============================================================================
module bldc_encoder_emulator #(
    parameter int COUNT_WIDTH  = 15,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    bldc_encoder_emulator_if.slave bus
);

    localparam logic [COUNT_WIDTH-1:0]  c_POS_ONE    = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_WIDTH-1:0] c_PERIOD_ONE = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MOVE = 1'b1
    } state_t;

    state_t                  r_state;
    logic [COUNT_WIDTH-1:0]  r_target;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic [PERIOD_WIDTH-1:0] r_div;
    logic [COUNT_WIDTH-1:0]  r_position;
    logic [1:0]              r_enc;
    logic                    r_done;

    state_t                  w_state_next;
    logic [COUNT_WIDTH-1:0]  w_target_next;
    logic [PERIOD_WIDTH-1:0] w_period_next;
    logic [PERIOD_WIDTH-1:0] w_div_next;
    logic [COUNT_WIDTH-1:0]  w_position_next;
    logic                    w_done_next;
    logic [COUNT_WIDTH-1:0]  w_diff;
    logic [COUNT_WIDTH-1:0]  w_stepped;
    logic [PERIOD_WIDTH-1:0] w_period_in;

    // A zero period would never fire the divider; clamp it to one clock.
    assign w_period_in = (bus.step_period == '0) ? c_PERIOD_ONE : bus.step_period;
    assign w_diff      = r_target - r_position;
    assign w_stepped   = w_diff[COUNT_WIDTH-1] ? (r_position - c_POS_ONE)
                                               : (r_position + c_POS_ONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_target   <= '0;
            r_period   <= c_PERIOD_ONE;
            r_div      <= '0;
            r_position <= '0;
            r_enc      <= 2'b00;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_target   <= w_target_next;
            r_period   <= w_period_next;
            r_div      <= w_div_next;
            r_position <= w_position_next;
            // Phase tracks position mod 4, so one step always flips one bit.
            r_enc      <= {w_position_next[1], w_position_next[1] ^ w_position_next[0]};
            r_done     <= w_done_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_target_next   = r_target;
        w_period_next   = r_period;
        w_div_next      = r_div;
        w_position_next = r_position;
        w_done_next     = 1'b0;

        if (bus.load) begin
            // Retarget wins over completion and suppresses any step this edge.
            w_state_next  = S_MOVE;
            w_target_next = bus.target;
            w_period_next = w_period_in;
            w_div_next    = '0;
        end else if (r_state == S_MOVE) begin
            if (w_diff == '0) begin
                w_state_next = S_IDLE;
                w_done_next  = 1'b1;
                w_div_next   = '0;
            end else if (r_div == (r_period - c_PERIOD_ONE)) begin
                w_position_next = w_stepped;
                w_div_next      = '0;
                if (w_stepped == r_target) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end
            end else begin
                w_div_next = r_div + c_PERIOD_ONE;
            end
        end
    end

    assign bus.enc      = r_enc;
    assign bus.position = r_position;
    assign bus.busy     = (r_state == S_MOVE);
    assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bldc_encoder_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_bldc_encoder_emulator
// Purpose  : Scoreboard bench for the BLDC encoder emulator.
// Revision : 1.0
// ============================================================================
module tb_bldc_encoder_emulator;

    localparam int CW = 15;
    localparam int PW = 16;

    typedef struct {
        int             cyc;
        logic [CW-1:0]  pos;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    bldc_encoder_emulator_if #(.COUNT_WIDTH(CW), .PERIOD_WIDTH(PW)) bus ();

    bldc_encoder_emulator #(.COUNT_WIDTH(CW), .PERIOD_WIDTH(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    exp_t sb[$];

    logic [1:0] enc_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    // Reference trajectory: start point, direction, step count and rate of the current move.
    bit            m_active = 1'b0;
    logic [CW-1:0] m_p0     = '0;
    logic [CW-1:0] m_idle   = '0;
    bit            m_up     = 1'b1;
    int            m_steps  = 0;
    int            m_P      = 1;
    int            m_t0     = 0;
    int            m_done   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s at cycle %0d: bound expired", name, cyc);
    endtask

    function automatic logic [CW-1:0] model_pos(input int n);
        int k;
        if (!m_active) return m_idle;
        k = (n - m_t0) / m_P;
        if (k < 0) k = 0;
        if (k > m_steps) k = m_steps;
        return m_up ? (m_p0 + CW'(k)) : (m_p0 - CW'(k));
    endfunction

    function automatic int enc_idx(input logic [1:0] e);
        for (int i = 0; i < 4; i++) if (enc_seq[i] == e) return i;
        return 0;
    endfunction

    // Called at the negedge before the load edge, which is edge number cyc+1.
    task automatic model_load(input logic [CW-1:0] tgt, input int sp);
        int            t1;
        logic [CW-1:0] p0;
        logic [CW-1:0] d;
        exp_t          e;
        t1 = cyc + 1;
        p0 = model_pos(t1 - 1);
        if (sb.size() > 0 && sb[$].cyc >= t1) void'(sb.pop_back());
        d = tgt - p0;
        if (d[CW-1]) begin
            m_up    = 1'b0;
            m_steps = (1 << CW) - int'(d);
        end else begin
            m_up    = 1'b1;
            m_steps = int'(d);
        end
        m_P      = (sp == 0) ? 1 : sp;
        m_p0     = p0;
        m_t0     = t1;
        m_active = 1'b1;
        m_done   = t1 + ((m_steps == 0) ? 1 : m_steps * m_P);
        e.cyc = m_done;
        e.pos = tgt;
        sb.push_back(e);
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_idle   = '0;
        sb.delete();
    endtask

    task automatic issue(input logic [CW-1:0] tgt, input int sp);
        @(negedge clk);
        model_load(tgt, sp);
        bus.load        = 1'b1;
        bus.target      = tgt;
        bus.step_period = PW'(sp);
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (!bus.busy && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) fail_now("wait_done");
    endtask

    // Monitor: per-cycle trajectory check, quadrature decode, done scoreboard.
    logic [CW-1:0] qcnt     = '0;
    logic [1:0]    prev_enc = 2'b00;

    initial begin
        exp_t e;
        int   ip;
        int   ic;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (reset) begin
                prev_enc = 2'b00;
                qcnt     = '0;
                continue;
            end
            if (bus.enc != prev_enc) begin
                ip = enc_idx(prev_enc);
                ic = enc_idx(bus.enc);
                check("enc_one_bit", $countones(bus.enc ^ prev_enc), 1);
                if (ic == (ip + 1) % 4) qcnt = qcnt + 1'b1;
                else if (ic == (ip + 3) % 4) qcnt = qcnt - 1'b1;
                prev_enc = bus.enc;
            end
            check("position", int'(bus.position), int'(model_pos(cyc)));
            check("busy", int'(bus.busy), int'(m_active && cyc < m_done));
            check("enc_phase", int'(bus.enc), int'(enc_seq[model_pos(cyc) % 4]));
            if (bus.done) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("done_position", int'(bus.position), int'(e.pos));
                    check("decoder_count", int'(qcnt), int'(bus.position));
                end
            end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                fail_now("missing_done");
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [CW-1:0] cur;
        bit            found;
        int            off;
        bus.load        = 1'b0;
        bus.target      = '0;
        bus.step_period = '0;

        repeat (3) @(negedge clk);
        check("reset_enc", int'(bus.enc), 0);
        check("reset_position", int'(bus.position), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        reset = 1'b0;

        // Four up-steps at three clocks each.
        issue(CW'(4), 3);
        wait_done(100);
        // Back to zero, then downward across the wrap to 0x7FFE.
        issue(CW'(0), 1);
        wait_done(100);
        issue(CW'(15'h7FFE), 1);
        wait_done(100);
        // Upward across the wrap to zero.
        issue(CW'(0), 2);
        wait_done(100);
        // Zero period: one edge per clock.
        issue(CW'(3), 0);
        wait_done(100);
        // Load onto the current position: done without any edge.
        issue(CW'(3), 5);
        wait_done(100);
        issue(CW'(0), 1);
        wait_done(100);
        // Reversal mid-move.
        issue(CW'(10), 3);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.position == CW'(2)) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) fail_now("reach_position_2");
        issue(CW'(0), 2);
        wait_done(200);

        // Random moves with random retargets.
        for (int i = 0; i < 60; i++) begin
            cur = model_pos(cyc);
            off = int'($urandom_range(0, 40)) - 20;
            issue(cur + CW'(off), int'($urandom_range(0, 4)));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(0, 12)) @(negedge clk);
            else wait_done(400);
        end
        wait_done(400);

        // Asynchronous reset mid-move, with a load held during reset.
        issue(model_pos(cyc) + CW'(30), 3);
        repeat (10) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_enc", int'(bus.enc), 0);
        check("async_reset_position", int'(bus.position), 0);
        check("async_reset_busy", int'(bus.busy), 0);
        check("async_reset_done", int'(bus.done), 0);
        model_reset();
        bus.load   = 1'b1;
        bus.target = CW'(7);
        repeat (2) @(negedge clk);
        bus.load = 1'b0;
        reset    = 1'b0;
        repeat (3) @(negedge clk);
        issue(CW'(5), 1);
        wait_done(100);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bldc_encoder_emulator.md
BLDC_ENCODER_EMULATOR -- requirements
Module: BLDC_Encoder_Emulator

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 15: width of position/target, modulo-2^COUNT_WIDTH arithmetic.
REQ-002 SHALL have parameter PERIOD_WIDTH, default 16: width of step_period.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on posedge clk.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load  input  1  request to start or retarget a move to target.
REQ-006 SHALL have port target  input  COUNT_WIDTH  desired position, sampled when load=1.
REQ-007 SHALL have port step_period  input  PERIOD_WIDTH  clocks between quadrature edges, sampled when load=1.
REQ-008 SHALL have port enc  output  2  emulated quadrature pair {A,B}, registered.
REQ-009 SHALL have port position  output  COUNT_WIDTH  count of emitted edges, signed-modular, registered.
REQ-010 SHALL have port busy  output  1  high while a move is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse on move completion.

Function
REQ-012 SHALL implement FSM states IDLE and MOVE; IDLE->MOVE on load, MOVE->IDLE when position equals latched target.
REQ-013 SHALL latch target and P = max(step_period,1) on every clock edge where load=1, in either state.
REQ-014 SHALL compute diff = latched_target - position modulo 2^COUNT_WIDTH; diff MSB=1 means move down, else up; diff = 2^(COUNT_WIDTH-1) moves down.
REQ-015 SHALL, when moving up, advance enc 00->01->11->10->00 and increment position by 1 per edge.
REQ-016 SHALL, when moving down, advance enc 00->10->11->01->00 and decrement position by 1 per edge.
REQ-017 SHALL change exactly one enc bit per edge; enc and position SHALL update on the same clock edge.
REQ-018 SHALL clear the interval divider on load, emit the first edge P clocks after the load edge, and subsequent edges every P clocks.
REQ-019 SHALL wrap position modulo 2^COUNT_WIDTH (max+1 -> 0, 0-1 -> max) with no saturation.
REQ-020 SHALL, on load during MOVE, keep current enc phase and position, restart the divider, recompute direction; a reversal SHALL be a legal single-bit step.
REQ-021 SHALL, on load with target equal to position, emit no enc edge and pulse done one clock after the load edge.
REQ-022 SHALL, on the edge emitting the final step, set busy=0 and done=1 for exactly one cycle.
REQ-023 SHALL give load priority over completion when both occur on the same edge: no done pulse, move continues toward the new target.
REQ-024 SHALL keep enc, position constant and busy=0 in IDLE.

Reset
REQ-025 SHALL, while reset=1, force enc=00, position=0, busy=0, done=0, divider=0, latched target=0, P=1, state IDLE, independent of clk.
REQ-026 SHALL abort any move on reset mid-operation; load is ignored until reset deasserts.

Verification
REQ-027 SHALL cover: target=4, step_period=3 from reset -> enc 01,11,10,00 at edges 3,6,9,12 after load; position 1..4; done pulse at edge 12; busy low after.
REQ-028 SHALL cover: position=0, target=0x7FFE (COUNT_WIDTH=15) -> direction down, enc 10,11 over 2 edges, position 0x7FFF then 0x7FFE, done.
REQ-029 SHALL cover: step_period=0, target=3 -> one edge per clock, done 3 clocks after load.
REQ-030 SHALL cover: load target=10 then after 2 edges load target=0 -> immediate reversal, single-bit steps only, position returns 2->0, one done only.
REQ-031 SHALL cover: reset asserted asynchronously mid-move -> enc=00, position=0, busy=0 before next clk edge.
REQ-032 SHALL cover: enc fed to the team's quadrature encoder counter over random targets/periods -> counter value equals position at every done pulse.
